bin2bcd_seq: RTL and testbench

Sequential double-dabble converter that turns an unsigned binary operand into a two-digit packed BCD value (tens digit in [7:4], units digit in [3:0]). It is the stage directly upstream of the two-digit BCD adder and produces its 8-bit `a`/`b` operands. One conversion takes a fixed number of shift cycles. Valid/ready handshakes are used on both sides so the block can be stalled by the adder-side control.

---
 rtl/bin2bcd_seq_if.sv | 24 ++
 rtl/bin2bcd_seq.sv | 95 +++++++++
 tb/tb_bin2bcd_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between the binary producer and the bin2bcd_seq converter.
// The producer side uses master, the converter uses slave.
interface bin2bcd_seq_if #(
    parameter int unsigned IN_W = 7
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] bin_in;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      bcd_out;
    logic            ovf;
    logic            busy;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, ovf, busy
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, ovf, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to two-digit packed BCD converter.
// Define BIN2BCD_SAT_EN to saturate results above 99 to 8'h99.
module bin2bcd_seq #(
    parameter int unsigned IN_W = 7
) (
    input logic          clk,
    input logic          rst,
    bin2bcd_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(IN_W + 1);

    if (IN_W < 4 || IN_W > 7) begin : g_bad_width
        $error("bin2bcd_seq: IN_W must be in 4..7");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [11:0]     scratch;
    logic [11:0]     scratch_adj;
    logic [11:0]     scratch_nx;
    logic [IN_W-1:0] sr;
    logic [CW-1:0]   cnt;
    logic [7:0]      bcd_q;
    logic            ovf_q;
    logic            accept;
    logic            last;

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (state == SHIFT) && (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.bcd_out   = bcd_q;
        bus.ovf       = ovf_q;
    end

    // Each digit is corrected on its own; inter-digit carries come only from the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int unsigned d = 0; d < 3; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        scratch_nx = {scratch_adj[10:0], sr[IN_W-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch <= '0;
            sr      <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            scratch <= '0;
            sr      <= bus.bin_in;
            cnt     <= CW'(IN_W);
        end else if (state == SHIFT) begin
            scratch <= scratch_nx;
            sr      <= {sr[IN_W-2:0], 1'b0};
            cnt     <= cnt - CW'(1);
            if (last) begin
`ifdef BIN2BCD_SAT_EN
                bcd_q <= (scratch_nx[11:8] != '0) ? 8'h99 : scratch_nx[7:0];
`else
                bcd_q <= scratch_nx[7:0];
`endif
                ovf_q <= (scratch_nx[11:8] != '0);
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (IN_W=7 and IN_W=4 instances).
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq_if #(.IN_W(7)) b7 ();
    bin2bcd_seq_if #(.IN_W(4)) b4 ();

    bin2bcd_seq #(.IN_W(7)) dut7 (.clk(clk), .rst(rst), .bus(b7));
    bin2bcd_seq #(.IN_W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    typedef struct {
        logic [6:0] bin;
        logic [7:0] bcd;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals7(input string tag);
        check({tag, "_in_ready"},  b7.in_ready,  1);
        check({tag, "_out_valid"}, b7.out_valid, 0);
        check({tag, "_busy"},      b7.busy,      0);
        check({tag, "_bcd"},       b7.bcd_out,   8'h00);
        check({tag, "_ovf"},       b7.ovf,       0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge right after the accepting edge.
    task automatic send7(input logic [6:0] v);
        int t = 0;
        b7.bin_in   = v;
        b7.in_valid = 1'b1;
        while (!b7.in_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("send7_ready", b7.in_ready, 1);
        @(negedge clk);
        b7.in_valid = 1'b0;
    endtask

    task automatic wait_done7(output int lat);
        lat = 0;
        while (!b7.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        int prev;
        int t;
        logic [7:0] exp_bcd;

        vecs[0] = '{7'd0,   8'h00, 1'b0};
        vecs[1] = '{7'd9,   8'h09, 1'b0};
        vecs[2] = '{7'd10,  8'h10, 1'b0};
        vecs[3] = '{7'd19,  8'h19, 1'b0};
        vecs[4] = '{7'd80,  8'h80, 1'b0};
        vecs[5] = '{7'd99,  8'h99, 1'b0};
`ifdef BIN2BCD_SAT_EN
        vecs[6] = '{7'd100, 8'h99, 1'b1};
        vecs[7] = '{7'd127, 8'h99, 1'b1};
        vecs[8] = '{7'd113, 8'h99, 1'b1};
`else
        vecs[6] = '{7'd100, 8'h00, 1'b1};
        vecs[7] = '{7'd127, 8'h27, 1'b1};
        vecs[8] = '{7'd113, 8'h13, 1'b1};
`endif

        b7.in_valid = 1'b0; b7.bin_in = '0; b7.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.bin_in = '0; b4.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals7("reset");

        // First conversion: latency and return of in_ready
        send7(7'd42);
        check("lat42_busy_shift", b7.busy, 1);
        check("lat42_ready_low", b7.in_ready, 0);
        wait_done7(lat);
        check("lat42_latency", lat, 7);
        check("lat42_bcd", b7.bcd_out, 8'h42);
        check("lat42_ovf", b7.ovf, 0);
        @(negedge clk);
        check("lat42_ready_back", b7.in_ready, 1);
        check("lat42_valid_drop", b7.out_valid, 0);

        for (int i = 0; i < 9; i++) begin
            send7(vecs[i].bin);
            wait_done7(lat);
            check($sformatf("vec%0d_latency", vecs[i].bin), lat, 7);
            check($sformatf("vec%0d_bcd", vecs[i].bin), b7.bcd_out, vecs[i].bcd);
            check($sformatf("vec%0d_ovf", vecs[i].bin), b7.ovf, vecs[i].ovf);
            @(negedge clk);
        end

        // Back-to-back sweep with in_valid held high
        prev = 0;
        b7.in_valid = 1'b1;
        for (int v = 0; v < 100; v++) begin
            b7.bin_in = 7'(v);
            t = 0;
            while (!b7.in_ready && t < 30) begin
                @(negedge clk);
                t++;
            end
            check("sweep_ready", b7.in_ready, 1);
            acc = cyc;
            if (v > 0) check("sweep_spacing", acc - prev, 9);
            prev = acc;
            @(negedge clk);
            wait_done7(lat);
            exp_bcd = 8'(((v / 10) << 4) | (v % 10));
            check($sformatf("sweep%0d_bcd", v), b7.bcd_out, exp_bcd);
            check($sformatf("sweep%0d_ovf", v), b7.ovf, 0);
        end
        b7.in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: hold 57 in DONE while stray in_valid pulses arrive
        b7.out_ready = 1'b0;
        send7(7'd57);
        wait_done7(lat);
        check("bp_latency", lat, 7);
        for (int i = 0; i < 5; i++) begin
            b7.in_valid = (i % 2 == 0);
            b7.bin_in   = 7'd3;
            @(negedge clk);
            check("bp_valid", b7.out_valid, 1);
            check("bp_bcd", b7.bcd_out, 8'h57);
            check("bp_ovf", b7.ovf, 0);
            check("bp_ready_low", b7.in_ready, 0);
        end
        b7.in_valid  = 1'b0;
        b7.out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_back", b7.in_ready, 1);
        check("bp_valid_drop", b7.out_valid, 0);
        @(negedge clk);
        check("bp_no_accept", b7.busy, 0);
        check("bp_bcd_held", b7.bcd_out, 8'h57);

        // Asynchronous reset in the third SHIFT cycle
        send7(7'd88);
        repeat (2) @(negedge clk);
        check("rst_mid_busy_before", b7.busy, 1);
        #2 rst = 1'b1;
        #1 check_reset_vals7("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals7("rst_rel");
        send7(7'd5);
        wait_done7(lat);
        check("post_rst_latency", lat, 7);
        check("post_rst_bcd", b7.bcd_out, 8'h05);
        check("post_rst_ovf", b7.ovf, 0);
        @(negedge clk);

        // Narrow instance: IN_W=4, operand 15
        b4.bin_in   = 4'd15;
        b4.in_valid = 1'b1;
        t = 0;
        while (!b4.in_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("w4_ready", b4.in_ready, 1);
        @(negedge clk);
        b4.in_valid = 1'b0;
        lat = 0;
        while (!b4.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("w4_latency", lat, 4);
        check("w4_bcd", b4.bcd_out, 8'h15);
        check("w4_ovf", b4.ovf, 0);
        @(negedge clk);
        check("w4_ready_back", b4.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
